vga_timing_gen: RTL and testbench

- Generates raster timing for the VGA output path: horizontal/vertical pixel counters, sync pulses and blanking flags.
- Default geometry is 800x600@60 Hz SVGA: 1056 x 628 total, 40 MHz pixel clock.
- Sits directly upstream of the drawing/colour stage, which consumes hcount/vcount/blank and forwards hs/vs with r/g/b to the pins.
- All outputs are registered, so hcount, vcount and every flag describe the same pixel in the same cycle.

---
 rtl/vga_timing_gen.sv | 98 +++++++++
 tb/tb_vga_timing_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, sync pulses, blanking and frame-start flags.
// Optional `define VGA_TIMING_GEN_FRAME_CNT_EN adds a 16-bit frame counter output.
module vga_timing_gen #(
  parameter int   H_VISIBLE = 800,
  parameter int   H_FRONT   = 40,
  parameter int   H_SYNC    = 128,
  parameter int   H_BACK    = 88,
  parameter int   V_VISIBLE = 600,
  parameter int   V_FRONT   = 1,
  parameter int   V_SYNC    = 4,
  parameter int   V_BACK    = 23,
  parameter logic SYNC_POL  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        hblnk,
  output logic        vblnk,
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
  output logic [15:0] frame_cnt,
`endif
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  // Counters are 11 bits wide, so neither raster dimension may exceed 2048.
  if ((H_TOTAL > 2048) || (V_TOTAL > 2048)) begin : g_geometry_check
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must both be <= 2048");
  end

  logic [10:0] h_next;
  logic [10:0] v_next;
  logic        frame_wrap;

  always_comb begin
    h_next     = hcount + 11'd1;
    v_next     = vcount;
    frame_wrap = 1'b0;
    if (hcount == H_LAST) begin
      h_next = '0;
      if (vcount == V_LAST) begin
        v_next     = '0;
        frame_wrap = 1'b1;
      end else begin
        v_next = vcount + 11'd1;
      end
    end
  end

  // Flags decode the next position so they land in the same register stage as the counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      frame_start <= 1'b1;
    end else begin
      hcount      <= h_next;
      vcount      <= v_next;
      hsync       <= ((h_next >= HS_START) && (h_next <= HS_END)) ? SYNC_POL : ~SYNC_POL;
      vsync       <= ((v_next >= VS_START) && (v_next <= VS_END)) ? SYNC_POL : ~SYNC_POL;
      hblnk       <= (h_next >= H_VIS);
      vblnk       <= (v_next >= V_VIS);
      frame_start <= (h_next == '0) && (v_next == '0);
    end
  end

`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
    end else if (frame_wrap) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`else
  logic unused_frame_wrap;
  assign unused_frame_wrap = frame_wrap;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed testbench for vga_timing_gen: default SVGA instance plus a tiny active-low-sync
// instance (16 x 12 raster) so full frames fit in a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] d_hcount, d_vcount, s_hcount, s_vcount;
  logic d_hsync, d_vsync, d_hblnk, d_vblnk, d_frame_start;
  logic s_hsync, s_vsync, s_hblnk, s_vblnk, s_frame_start;
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
  logic [15:0] d_frame_cnt, s_frame_cnt;
`endif

  vga_timing_gen dut (
    .clk(clk), .rst(rst), .hcount(d_hcount), .vcount(d_vcount),
    .hsync(d_hsync), .vsync(d_vsync), .hblnk(d_hblnk), .vblnk(d_vblnk),
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    .frame_cnt(d_frame_cnt),
`endif
    .frame_start(d_frame_start)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
    .SYNC_POL(1'b0)
  ) dut_s (
    .clk(clk), .rst(rst), .hcount(s_hcount), .vcount(s_vcount),
    .hsync(s_hsync), .vsync(s_vsync), .hblnk(s_hblnk), .vblnk(s_vblnk),
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    .frame_cnt(s_frame_cnt),
`endif
    .frame_start(s_frame_start)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Reference raster position derived from the number of clocks since reset release.
  task automatic checkModel();
    int dh, dv, sh, sv;
    dh = cyc % 1056;
    dv = (cyc / 1056) % 628;
    sh = cyc % 16;
    sv = (cyc / 16) % 12;
    checkOutput("d_hcount", d_hcount, dh);
    checkOutput("d_vcount", d_vcount, dv);
    checkOutput("d_hsync", d_hsync, (dh >= 840 && dh <= 967) ? 1 : 0);
    checkOutput("d_vsync", d_vsync, (dv >= 601 && dv <= 604) ? 1 : 0);
    checkOutput("d_hblnk", d_hblnk, (dh >= 800) ? 1 : 0);
    checkOutput("d_vblnk", d_vblnk, (dv >= 600) ? 1 : 0);
    checkOutput("d_frame_start", d_frame_start, (dh == 0 && dv == 0) ? 1 : 0);
    checkOutput("s_hcount", s_hcount, sh);
    checkOutput("s_vcount", s_vcount, sv);
    checkOutput("s_hsync", s_hsync, (sh >= 10 && sh <= 12) ? 0 : 1);
    checkOutput("s_vsync", s_vsync, (sv >= 7 && sv <= 8) ? 0 : 1);
    checkOutput("s_hblnk", s_hblnk, (sh >= 8) ? 1 : 0);
    checkOutput("s_vblnk", s_vblnk, (sv >= 6) ? 1 : 0);
    checkOutput("s_frame_start", s_frame_start, (sh == 0 && sv == 0) ? 1 : 0);
  endtask

  initial begin
    int hs_cnt, hs_first, hs_last, hb_first, hb_cnt;
    int fs_d, fs_s, vs_s_cnt, last_vs_edge, spacing;
    logic prev_vs_s;
    hs_cnt = 0; hs_first = -1; hs_last = -1; hb_first = -1; hb_cnt = 0;
    fs_d = 0; fs_s = 0; vs_s_cnt = 0; last_vs_edge = -1; spacing = -1;
    prev_vs_s = 1'b1;

    // Reset held for five clocks.
    applyStimulus(5);
    checkOutput("rst_hcount", d_hcount, 0);
    checkOutput("rst_vcount", d_vcount, 0);
    checkOutput("rst_hsync", d_hsync, 0);
    checkOutput("rst_vsync", d_vsync, 0);
    checkOutput("rst_hblnk", d_hblnk, 0);
    checkOutput("rst_vblnk", d_vblnk, 0);
    checkOutput("rst_frame_start", d_frame_start, 1);
    checkOutput("rst_s_hsync", s_hsync, 1);
    checkOutput("rst_s_vsync", s_vsync, 1);
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    checkOutput("rst_frame_cnt", d_frame_cnt, 0);
`endif

    // Release and first edge.
    rst = 1'b1;
    cyc = 0;
    applyStimulus(1);
    checkOutput("rel_hcount", d_hcount, 1);
    checkOutput("rel_vcount", d_vcount, 0);
    checkOutput("rel_frame_start", d_frame_start, 0);

    // Two full lines of the default raster, many frames of the small one.
    for (int i = 0; i < 2200; i++) begin
      if (i > 0) applyStimulus(1);
      checkModel();
      if (cyc < 1056) begin
        if (d_hsync) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = int'(d_hcount);
          hs_last = int'(d_hcount);
        end
        if (d_hblnk) begin
          hb_cnt++;
          if (hb_first < 0) hb_first = int'(d_hcount);
        end
      end
      if (cyc == 1056) begin
        checkOutput("wrap_hcount", d_hcount, 0);
        checkOutput("wrap_vcount", d_vcount, 1);
      end
      if (d_frame_start) fs_d++;
      if (s_frame_start) fs_s++;
      if (!s_vsync) vs_s_cnt++;
      if (!s_vsync && prev_vs_s) begin
        if (last_vs_edge >= 0) spacing = cyc - last_vs_edge;
        last_vs_edge = cyc;
      end
      prev_vs_s = s_vsync;
    end
    checkOutput("hsync_cycles", hs_cnt, 128);
    checkOutput("hsync_first", hs_first, 840);
    checkOutput("hsync_last", hs_last, 967);
    checkOutput("hblnk_first", hb_first, 800);
    checkOutput("hblnk_cycles", hb_cnt, 256);
    checkOutput("d_frame_start_cnt", fs_d, 0);
    checkOutput("s_frame_start_cnt", fs_s, 11);
    checkOutput("s_vsync_cycles", vs_s_cnt, 352);
    checkOutput("s_vsync_spacing", spacing, 192);

    // Advance to hcount 500 on line 2; small raster is then inside its vsync window.
    while (cyc < 2612) applyStimulus(1);
    checkOutput("pre_async_hcount", d_hcount, 500);
    checkOutput("pre_async_vcount", d_vcount, 2);
    checkOutput("pre_async_s_vsync", s_vsync, 0);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_hcount", d_hcount, 0);
    checkOutput("async_vcount", d_vcount, 0);
    checkOutput("async_hblnk", d_hblnk, 0);
    checkOutput("async_frame_start", d_frame_start, 1);
    checkOutput("async_s_vsync", s_vsync, 1);
    checkOutput("async_s_hcount", s_hcount, 0);
    checkOutput("async_s_vcount", s_vcount, 0);
    applyStimulus(2);
    checkOutput("held_hcount", d_hcount, 0);
    rst = 1'b1;
    cyc = 0;
    applyStimulus(1);
    checkOutput("restart_hcount", d_hcount, 1);
    checkOutput("restart_vcount", d_vcount, 0);
    checkOutput("restart_s_hcount", s_hcount, 1);

`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    while (cyc < 191) applyStimulus(1);
    checkOutput("fc_before_wrap", s_frame_cnt, 0);
    for (int k = 1; k <= 3; k++) begin
      while (cyc < 192 * k) applyStimulus(1);
      checkOutput("fc_wrap", s_frame_cnt, k);
      checkOutput("fc_frame_start", s_frame_start, 1);
    end
    checkOutput("fc_default", d_frame_cnt, 0);
    while (cyc < 767) applyStimulus(1);
    force dut_s.frame_cnt = 16'hFFFF;
    #1 release dut_s.frame_cnt;
    applyStimulus(1);
    checkOutput("fc_rollover", s_frame_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
